// File: rtl/multi_sensor_hub.sv
`default_nettype none
// ============================================================================
// Module   : multi_sensor_hub
// Brief    : UART command bridge; routes a 2-byte host frame to one of N_CH
//            sensor channels and returns a 2-byte status/data reply.
// Revision : 1.0 - initial release
// ============================================================================
module multi_sensor_hub #(
    parameter int N_CH           = 4,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic [N_CH-1:0]   o_En,
    output logic [7:0]        o_request,
    input  logic [N_CH-1:0]   i_Ch_Done,
    input  logic [8*N_CH-1:0] i_Ch_Data,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Done,
    output logic              o_busy
);

    localparam int ADDR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [8:0]       C_N_CH     = 9'(N_CH);
    localparam logic [N_CH-1:0]  C_ONE      = N_CH'(1);
    localparam logic [7:0]       C_ERR_ADDR = 8'hE0;
    localparam logic [7:0]       C_ERR_TMO  = 8'hE1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_ADDR = 3'd1;
    localparam logic [2:0] S_WAIT_RESP = 3'd2;
    localparam logic [2:0] S_SEND0     = 3'd3;
    localparam logic [2:0] S_WAIT_TX0  = 3'd4;
    localparam logic [2:0] S_SEND1     = 3'd5;
    localparam logic [2:0] S_WAIT_TX1  = 3'd6;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_cmd;
    logic [ADDR_W-1:0] r_sel;
    logic [7:0]        r_data;
    logic [N_CH-1:0]   r_en;
    logic [7:0]        r_request;
    logic              r_tx_dv;
    logic [7:0]        r_tx_byte;
    logic              r_busy;

    logic              w_addr_ok;
    logic [N_CH-1:0]   w_onehot;
    logic              w_sel_done;
    logic [7:0]        w_sel_data;
    logic              w_expired;

    assign w_addr_ok  = ({1'b0, i_Rx_Byte} < C_N_CH);
    assign w_onehot   = C_ONE << i_Rx_Byte[ADDR_W-1:0];
    assign w_sel_done = i_Ch_Done[r_sel];
    assign w_sel_data = i_Ch_Data[{r_sel, 3'b000} +: 8];
    assign w_expired  = (r_cnt == C_CNT_LAST);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cmd     <= '0;
            r_sel     <= '0;
            r_data    <= '0;
            r_en      <= '0;
            r_request <= '0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_tx_dv <= 1'b0;
            // Saturating count; every transition below restarts it from zero.
            if (r_cnt != C_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_Rx_DV) begin
                        r_cmd   <= i_Rx_Byte;
                        r_cnt   <= '0;
                        r_state <= S_WAIT_ADDR;
                    end
                end
                S_WAIT_ADDR: begin
                    if (i_Rx_DV) begin
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (w_addr_ok) begin
                            r_sel     <= i_Rx_Byte[ADDR_W-1:0];
                            r_en      <= w_onehot;
                            r_request <= r_cmd;
                            r_state   <= S_WAIT_RESP;
                        end else begin
                            r_data    <= '0;
                            r_tx_byte <= C_ERR_ADDR;
                            r_tx_dv   <= 1'b1;
                            r_state   <= S_SEND0;
                        end
                    end else if (w_expired) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_RESP: begin
                    // A done from the selected channel wins over a coincident timeout.
                    if (w_sel_done || w_expired) begin
                        r_cnt     <= '0;
                        r_en      <= '0;
                        r_request <= '0;
                        r_tx_dv   <= 1'b1;
                        r_state   <= S_SEND0;
                        if (w_sel_done) begin
                            r_data    <= w_sel_data;
                            r_tx_byte <= 8'(r_sel);
                        end else begin
                            r_data    <= '0;
                            r_tx_byte <= C_ERR_TMO;
                        end
                    end
                end
                S_SEND0: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_TX0;
                end
                S_WAIT_TX0: begin
                    if (i_Tx_Done) begin
                        r_cnt     <= '0;
                        r_tx_byte <= r_data;
                        r_tx_dv   <= 1'b1;
                        r_state   <= S_SEND1;
                    end
                end
                S_SEND1: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_TX1;
                end
                S_WAIT_TX1: begin
                    if (i_Tx_Done) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_en    <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_En      = r_en;
    assign o_request = r_request;
    assign o_Tx_DV   = r_tx_dv;
    assign o_Tx_Byte = r_tx_byte;
    assign o_busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_multi_sensor_hub.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_sensor_hub
// Brief    : Directed scoreboard bench for multi_sensor_hub (N_CH=4, timeout 1000).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_sensor_hub;

    localparam int N_CH  = 4;
    localparam int T_OUT = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic [N_CH-1:0]   en;
    logic [7:0]        request;
    logic [N_CH-1:0]   ch_done;
    logic [8*N_CH-1:0] ch_data;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              tx_done;
    logic              busy;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    multi_sensor_hub #(.N_CH(N_CH), .TIMEOUT_CYCLES(T_OUT)) dut (
        .i_Clock  (clk),
        .i_Reset  (rst),
        .i_Rx_DV  (rx_dv),
        .i_Rx_Byte(rx_byte),
        .o_En     (en),
        .o_request(request),
        .i_Ch_Done(ch_done),
        .i_Ch_Data(ch_data),
        .o_Tx_DV  (tx_dv),
        .o_Tx_Byte(tx_byte),
        .i_Tx_Done(tx_done),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every Tx pulse must match the oldest queued byte; an empty queue means an unexpected pulse.
    always @(negedge clk) begin
        if (tx_dv === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tx", 32'(tx_byte), 32'hFFFF_FFFF);
            end else begin
                check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic rx(input logic [7:0] b);
        @(negedge clk); rx_dv = 1'b1; rx_byte = b;
        @(negedge clk); rx_dv = 1'b0; rx_byte = 8'h00;
    endtask

    task automatic done_pulse(input int ch, input logic [7:0] d);
        @(negedge clk); ch_done = N_CH'(1) << ch; ch_data[8*ch +: 8] = d;
        @(negedge clk); ch_done = '0;
    endtask

    task automatic send_tx_done();
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk); tx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
        ch_done = '0; ch_data = '0; tx_done = 1'b0;
        idle(3);
        check("rst_en", 32'(en), 32'h0);
        check("rst_request", 32'(request), 32'h0);
        check("rst_tx_dv", 32'(tx_dv), 32'h0);
        check("rst_tx_byte", 32'(tx_byte), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        idle(2);

        // Normal read of channel 2.
        rx(8'h01);
        check("nr_busy_wait_addr", 32'(busy), 32'h0);
        rx(8'h02);
        check("nr_en", 32'(en), 32'b0100);
        check("nr_request", 32'(request), 32'h01);
        check("nr_busy", 32'(busy), 32'h1);
        exp_q.push_back(8'h02); exp_q.push_back(8'h1A);
        done_pulse(2, 8'h1A);
        check("nr_latency", 32'(tx_dv), 32'h1);
        check("nr_en_clear", 32'(en), 32'h0);
        check("nr_request_clear", 32'(request), 32'h0);
        idle(2);
        check("nr_hold_byte0", 32'(tx_byte), 32'h02);
        send_tx_done();
        check("nr_send1_dv", 32'(tx_dv), 32'h1);
        send_tx_done();
        check("nr_busy_drop", 32'(busy), 32'h0);
        check("nr_queue_empty", 32'(exp_q.size()), 32'h0);

        // Invalid address.
        rx(8'h01);
        exp_q.push_back(8'hE0); exp_q.push_back(8'h00);
        rx(8'h07);
        check("ia_en", 32'(en), 32'h0);
        check("ia_dv", 32'(tx_dv), 32'h1);
        check("ia_busy", 32'(busy), 32'h1);
        send_tx_done();
        send_tx_done();
        check("ia_queue_empty", 32'(exp_q.size()), 32'h0);

        // Channel timeout: enable held for exactly T_OUT cycles.
        rx(8'h03);
        rx(8'h00);
        check("to_en", 32'(en), 32'b0001);
        check("to_request", 32'(request), 32'h03);
        exp_q.push_back(8'hE1); exp_q.push_back(8'h00);
        begin
            int held = 1;
            for (int i = 1; i < T_OUT; i++) begin
                @(negedge clk);
                if (en !== 4'b0001 || tx_dv !== 1'b0) held = 0;
            end
            check("to_en_held", 32'(held), 32'h1);
        end
        @(negedge clk);
        check("to_expire_en", 32'(en), 32'h0);
        check("to_expire_dv", 32'(tx_dv), 32'h1);
        send_tx_done();
        send_tx_done();
        check("to_queue_empty", 32'(exp_q.size()), 32'h0);

        // Wrong-channel done, dropped Rx byte and stray Tx_Done while channel 1 is selected.
        rx(8'h02);
        rx(8'h01);
        check("wc_en", 32'(en), 32'b0010);
        exp_q.push_back(8'h01); exp_q.push_back(8'h55);
        @(negedge clk);
        ch_done = 4'b1000; ch_data[31:24] = 8'h99; rx_dv = 1'b1; rx_byte = 8'h03; tx_done = 1'b1;
        @(negedge clk);
        ch_done = '0; rx_dv = 1'b0; rx_byte = 8'h00; tx_done = 1'b0;
        check("wc_ignore_dv", 32'(tx_dv), 32'h0);
        check("wc_en_held", 32'(en), 32'b0010);
        check("wc_request_held", 32'(request), 32'h02);
        idle(4);
        done_pulse(1, 8'h55);
        check("wc_dv", 32'(tx_dv), 32'h1);
        send_tx_done();
        send_tx_done();
        check("wc_queue_empty", 32'(exp_q.size()), 32'h0);

        // Lone command times out silently, then a fresh frame works.
        rx(8'h01);
        idle(T_OUT);
        rx(8'h04);
        rx(8'h00);
        check("lc_en", 32'(en), 32'b0001);
        check("lc_request", 32'(request), 32'h04);
        exp_q.push_back(8'h00); exp_q.push_back(8'h3C);
        done_pulse(0, 8'h3C);
        send_tx_done();
        send_tx_done();
        check("lc_queue_empty", 32'(exp_q.size()), 32'h0);

        // Reset during WAIT_TX0 aborts the frame.
        rx(8'h01);
        rx(8'h02);
        exp_q.push_back(8'h02);
        done_pulse(2, 8'h77);
        @(negedge clk);
        rst = 1'b1; rx_dv = 1'b1; rx_byte = 8'h05;
        @(negedge clk);
        rst = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
        check("rm_en", 32'(en), 32'h0);
        check("rm_busy", 32'(busy), 32'h0);
        check("rm_tx_byte", 32'(tx_byte), 32'h0);
        send_tx_done();
        idle(20);
        check("rm_busy_after", 32'(busy), 32'h0);
        check("rm_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_sensor_hub.md
MULTI_SENSOR_HUB -- requirements
Module: multi_sensor_hub

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of sensor interface channels (1..16).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100000000, meaning the cycle limit for both inter-byte wait and channel response wait (2 s at 50 MHz).
REQ-003 The block SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_Reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_Rx_DV, input, 1 bit: one-cycle pulse marking a valid received UART byte.
REQ-006 The block SHALL have port i_Rx_Byte, input, 8 bits: the received byte, valid only while i_Rx_DV=1.
REQ-007 The block SHALL have port o_En, output, N_CH bits: one-hot enable, with bit k selecting channel k.
REQ-008 The block SHALL have port o_request, output, 8 bits: the command code forwarded to the selected channel.
REQ-009 The block SHALL have port i_Ch_Done, input, N_CH bits: per-channel one-cycle pulse meaning the response is valid.
REQ-010 The block SHALL have port i_Ch_Data, input, 8*N_CH bits: channel k response on bits [8k+7:8k].
REQ-011 The block SHALL have port o_Tx_DV, output, 1 bit: one-cycle pulse that starts UART transmission of o_Tx_Byte.
REQ-012 The block SHALL have port o_Tx_Byte, output, 8 bits: the byte to transmit, held stable from the o_Tx_DV pulse until the matching i_Tx_Done.
REQ-013 The block SHALL have port i_Tx_Done, input, 1 bit: one-cycle pulse at the end of a UART byte.
REQ-014 The block SHALL have port o_busy, output, 1 bit: high in every state except IDLE and WAIT_ADDR.

Function
REQ-015 The host frame SHALL be two bytes: byte0 = command, then byte1 = channel address.
REQ-016 The response frame SHALL be two bytes: a status byte, then a data byte.
- Status byte = echoed address on success.
- Status byte = 0xE0 for an invalid address.
- Status byte = 0xE1 for a timeout.
- The data byte SHALL be 0x00 on any error.
REQ-017 The FSM states SHALL be exactly: IDLE, WAIT_ADDR, WAIT_RESP, SEND0, WAIT_TX0, SEND1, WAIT_TX1.
REQ-018 In IDLE, a byte arriving with i_Rx_DV=1 SHALL be latched as the command, and the FSM SHALL move to WAIT_ADDR.
REQ-019 In WAIT_ADDR, if no byte arrives within TIMEOUT_CYCLES cycles, the FSM SHALL return to IDLE silently, with no Tx.
REQ-020 In WAIT_ADDR, an address byte < N_CH arriving at edge t SHALL drive the following, all from edge t+1, and move the FSM to WAIT_RESP:
- o_En = one-hot(address);
- o_request = command.
REQ-021 In WAIT_ADDR, an address byte >= N_CH SHALL move the FSM to SEND0 with status 0xE0, and o_En SHALL stay 0.
REQ-022 o_En and o_request SHALL be held constant throughout WAIT_RESP and SHALL clear on the edge that leaves WAIT_RESP.
REQ-023 In WAIT_RESP, the block SHALL latch the selected channel's data slice on the cycle its i_Ch_Done bit is 1, and then move to SEND0.
- Done pulses from non-selected channels SHALL be ignored.
REQ-024 In WAIT_RESP, if the selected channel gives no done within TIMEOUT_CYCLES cycles of o_En rising, the FSM SHALL move to SEND0 with status 0xE1.
REQ-025 If done and timeout expiry occur in the same cycle, done SHALL take priority.
REQ-026 The timeout counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide.
- It SHALL clear on every state entry.
- It SHALL saturate rather than wrap.
REQ-027 In SEND0, the block SHALL pulse o_Tx_DV for exactly one cycle with o_Tx_Byte = status, then move to WAIT_TX0.
- Latency: the o_Tx_DV pulse SHALL occur exactly one cycle after the triggering i_Ch_Done or address byte.
REQ-028 On i_Tx_Done in WAIT_TX0, the FSM SHALL go to SEND1.
- SEND1 SHALL pulse o_Tx_DV with o_Tx_Byte = data byte.
- The FSM SHALL then go to WAIT_TX1.
REQ-029 On i_Tx_Done in WAIT_TX1, the FSM SHALL go to IDLE, with o_busy low on the next cycle.
REQ-030 i_Rx_DV SHALL be ignored, and its bytes dropped, while o_busy=1.
REQ-031 An i_Tx_Done outside WAIT_TX0 or WAIT_TX1 SHALL be ignored.

Reset
REQ-032 When i_Reset=1 at an edge, the block SHALL set the following, with reset priority over all other inputs:
- state = IDLE;
- o_En = 0;
- o_request = 0x00;
- o_Tx_DV = 0;
- o_Tx_Byte = 0x00;
- o_busy = 0;
- all counters and latches = 0.
REQ-033 A reset in any state SHALL abort the current frame, with no further o_Tx_DV pulse.
- Bytes received with i_Rx_DV during reset SHALL be discarded.

Verification
Bench parameters: N_CH=4, TIMEOUT_CYCLES=1000.
REQ-034 The bench SHALL cover a normal read: Rx 0x01 then 0x02, then i_Ch_Done[2] with slice 0x1A -> o_En=4'b0100 with o_request=0x01, then Tx 0x02 followed by 0x1A.
REQ-035 The bench SHALL cover an invalid address: Rx 0x01 then 0x07 -> o_En stays 0, and Tx is 0xE0 followed by 0x00.
REQ-036 The bench SHALL cover a channel timeout: Rx 0x03 then 0x00 with no done -> o_En=4'b0001 for 1000 cycles, then Tx 0xE1 followed by 0x00.
REQ-037 The bench SHALL cover a wrong-channel done plus a busy drop: while channel 1 is selected, pulse i_Ch_Done[3] and an Rx byte, then later i_Ch_Done[1] with 0x55 -> only 0x01 followed by 0x55 is transmitted.
REQ-038 The bench SHALL cover a lone command: Rx 0x01 alone -> return to IDLE after 1000 cycles with no Tx; the next 0x04 then 0x00 frame is processed normally.
REQ-039 The bench SHALL cover reset mid-frame: assert i_Reset during WAIT_TX0 -> o_En=0 and o_busy=0 after one edge, with no second o_Tx_DV pulse.
